// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// decoded operation classes, opcode/funct values, ALU and PC-select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RTYPE = 3'd1,
    OP_ADDIU = 3'd2,
    OP_LW    = 3'd3,
    OP_SW    = 3'd4,
    OP_BEQ   = 3'd5,
    OP_J     = 3'd6
  } op_class_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Operations whose second ALU operand is the sign-extended immediate.
  function automatic logic uses_imm(input op_class_t op);
    logic r;
    case (op)
      OP_ADDIU, OP_LW, OP_SW: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> operation class,
// ALU operation and legality.
import ctrl_pkg::*;

module ctrl_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output op_class_t  op_class,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  // Opcode and funct classification; anything unlisted is illegal.
  always_comb begin
    op_class = OP_NONE;
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADDU: begin op_class = OP_RTYPE; alu_ctrl = ALU_ADD; legal = 1'b1; end
          FN_SUBU: begin op_class = OP_RTYPE; alu_ctrl = ALU_SUB; legal = 1'b1; end
          FN_AND:  begin op_class = OP_RTYPE; alu_ctrl = ALU_AND; legal = 1'b1; end
          FN_OR:   begin op_class = OP_RTYPE; alu_ctrl = ALU_OR;  legal = 1'b1; end
          FN_SLT:  begin op_class = OP_RTYPE; alu_ctrl = ALU_SLT; legal = 1'b1; end
          default: begin op_class = OP_NONE;  alu_ctrl = ALU_ADD; legal = 1'b0; end
        endcase
      end
      OPC_ADDIU: begin op_class = OP_ADDIU; alu_ctrl = ALU_ADD; legal = 1'b1; end
      OPC_LW:    begin op_class = OP_LW;    alu_ctrl = ALU_ADD; legal = 1'b1; end
      OPC_SW:    begin op_class = OP_SW;    alu_ctrl = ALU_ADD; legal = 1'b1; end
      OPC_BEQ:   begin op_class = OP_BEQ;   alu_ctrl = ALU_SUB; legal = 1'b1; end
      OPC_J:     begin op_class = OP_J;     alu_ctrl = ALU_ADD; legal = 1'b1; end
      default:   begin op_class = OP_NONE;  alu_ctrl = ALU_ADD; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with fetch/memory handshakes and a
// retired-instruction counter. Define CTRL_ILLEGAL_TRAP_EN to trap on illegal ops.
import ctrl_pkg::*;

module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        if_req,
  input  logic        if_ack,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic        zero,
  output logic [2:0]  ALUctrl,
  output logic        ALUsrc,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        pc_wr,
  output logic [1:0]  pc_sel,
  output logic [31:0] retire_cnt,
  output logic        illegal
);

  state_t     state_r, state_nxt_s;
  logic [5:0] opcode_r, funct_r;
  op_class_t  op_class_s;
  logic [2:0] alu_ctrl_s;
  logic       legal_s;
  logic [31:0] retire_cnt_r;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  ctrl_decode u_decode (
    .opcode   (opcode_r),
    .funct    (funct_r),
    .op_class (op_class_s),
    .alu_ctrl (alu_ctrl_s),
    .legal    (legal_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Opcode/funct capture on the accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r <= 6'd0;
      funct_r  <= 6'd0;
    end else if (state_r == ST_FETCH && if_ack) begin
      opcode_r <= instr[31:26];
      funct_r  <= instr[5:0];
    end
  end

  // Retired-instruction counter, one step per PC update; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     retire_cnt_r <= 32'd0;
    else if (pc_wr) retire_cnt_r <= retire_cnt_r + 32'd1;
  end

  assign retire_cnt = retire_cnt_r;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                illegal_r <= 1'b0;
    else if (state_r == ST_DECODE && !legal_s) illegal_r <= 1'b1;
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // Next-state and strobe decode; handshake strobes depend on the acks directly.
  always_comb begin
    state_nxt_s = state_r;
    if_req      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ALUctrl     = ALU_ADD;
    ALUsrc      = 1'b0;
    ir_wr       = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_wr       = 1'b0;
    pc_sel      = PC_PLUS4;

    // ALU controls stay stable from EXEC through WB for address/result paths.
    if (state_r == ST_EXEC || state_r == ST_MEM || state_r == ST_WB) begin
      ALUctrl = alu_ctrl_s;
      ALUsrc  = uses_imm(op_class_s);
    end else begin
      ALUctrl = ALU_ADD;
      ALUsrc  = 1'b0;
    end

    case (state_r)
      ST_IDLE: state_nxt_s = ST_FETCH;

      ST_FETCH: begin
        if_req = 1'b1;
        if (if_ack) begin
          ir_wr       = 1'b1;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (legal_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt_s = ST_TRAP;
`else
          pc_wr       = 1'b1;
          pc_sel      = PC_PLUS4;
          state_nxt_s = ST_FETCH;
`endif
        end
      end

      ST_EXEC: begin
        case (op_class_s)
          OP_RTYPE, OP_ADDIU: state_nxt_s = ST_WB;
          OP_LW, OP_SW:       state_nxt_s = ST_MEM;
          OP_BEQ: begin
            pc_wr       = 1'b1;
            pc_sel      = zero ? PC_BRANCH : PC_PLUS4;
            state_nxt_s = ST_FETCH;
          end
          OP_J: begin
            pc_wr       = 1'b1;
            pc_sel      = PC_JUMP;
            state_nxt_s = ST_FETCH;
          end
          default: state_nxt_s = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class_s == OP_SW);
        if (mem_ack) begin
          if (op_class_s == OP_SW) begin
            pc_wr       = 1'b1;
            pc_sel      = PC_PLUS4;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else begin
          state_nxt_s = ST_MEM;
        end
      end

      ST_WB: begin
        reg_wr      = 1'b1;
        reg_dst     = (op_class_s == OP_RTYPE);
        mem_to_reg  = (op_class_s == OP_LW);
        pc_wr       = 1'b1;
        pc_sel      = PC_PLUS4;
        state_nxt_s = ST_FETCH;
      end

      ST_TRAP: state_nxt_s = ST_TRAP;

      default: state_nxt_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: expected PC-update strobes are queued per
// instruction and compared when the controller asserts pc_wr.
module tb_multi_cycle_ctrl;

  logic        clk, rst_n;
  logic [31:0] instr;
  logic        if_req, if_ack, mem_req, mem_we, mem_ack, zero;
  logic [2:0]  ALUctrl;
  logic        ALUsrc, ir_wr, reg_wr, reg_dst, mem_to_reg, pc_wr;
  logic [1:0]  pc_sel;
  logic [31:0] retire_cnt;
  logic        illegal;

  typedef struct {
    logic [8:0]  fields;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_cnt;
  int          n_cmp, n_bad;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .if_req(if_req), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .zero(zero),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .retire_cnt(retire_cnt), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Scoreboard pop on every PC update: {pc_sel, reg_wr, reg_dst, mem_to_reg, ALUctrl, ALUsrc}.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pc_wr) begin
      if (sb.size() == 0) begin
        check("pcwr_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pcwr_fields", {23'd0, pc_sel, reg_wr, reg_dst, mem_to_reg, ALUctrl, ALUsrc},
              {23'd0, e.fields});
        check("retire_before", retire_cnt, e.cnt);
      end
    end
    if (rst_n && reg_wr && !pc_wr) check("reg_wr_without_pcwr", 32'd1, 32'd0);
  end

  task automatic run_instr(input logic [31:0] word, input logic zv, input int lat,
                           input logic [8:0] fields, output int gap, output int mem_cyc,
                           output logic mem_we_seen);
    exp_t e;
    int   ack_c;
    bit   fetched, done;
    e.fields  = fields;
    e.cnt     = model_cnt;
    model_cnt = model_cnt + 32'd1;
    sb.push_back(e);
    zero = zv; fetched = 1'b0; done = 1'b0;
    mem_cyc = 0; mem_we_seen = 1'b0; gap = 0; ack_c = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if_ack  = 1'b0;
      mem_ack = 1'b0;
      if (fetched && sb.size() == 0) begin
        done = 1'b1;
        gap  = c - ack_c;
      end else begin
        if (!fetched && if_req) begin
          instr = word; if_ack = 1'b1; fetched = 1'b1; ack_c = c;
        end
        if (mem_req) begin
          mem_cyc++;
          mem_we_seen = mem_we_seen | mem_we;
          if (mem_cyc == lat + 1) mem_ack = 1'b1;
        end
      end
    end
    if (!done) check("instr_timeout", 32'd0, 32'd1);
    else       check("retire_after", retire_cnt, model_cnt);
  endtask

  initial begin
    int   gap, mcyc, cnt;
    logic we_seen;
    bit   hit;
    n_cmp = 0; n_bad = 0; model_cnt = 32'd0;
    rst_n = 1'b0; instr = 32'd0; if_ack = 1'b0; mem_ack = 1'b0; zero = 1'b0;
    #12;
    check("rst_outputs", {24'd0, if_req, mem_req, mem_we, ir_wr, reg_wr, pc_wr, pc_sel},
          32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("idle_no_if_req", {31'd0, if_req}, 32'd0);
    @(posedge clk); #1;
    check("first_if_req", {31'd0, if_req}, 32'd1);

    run_instr(32'h00221821, 1'b0, 0, {2'b00, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}, gap, mcyc, we_seen);
    check("addu_ack_to_if_req", gap, 32'd4);
    check("addu_if_req_back", {31'd0, if_req}, 32'd1);
    run_instr(32'h8C220004, 1'b0, 3, {2'b00, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1}, gap, mcyc, we_seen);
    check("lw_mem_req_cycles", mcyc, 32'd4);
    check("lw_mem_we", {31'd0, we_seen}, 32'd0);
    run_instr(32'hAC220004, 1'b0, 0, {2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1}, gap, mcyc, we_seen);
    check("sw_mem_req_cycles", mcyc, 32'd1);
    check("sw_mem_we", {31'd0, we_seen}, 32'd1);
    run_instr(32'h10220003, 1'b1, 0, {2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h10220003, 1'b0, 0, {2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h08000010, 1'b0, 0, {2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h24220005, 1'b0, 0, {2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1}, gap, mcyc, we_seen);
    run_instr(32'h00221823, 1'b0, 0, {2'b00, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h00221824, 1'b0, 0, {2'b00, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h00221825, 1'b0, 0, {2'b00, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h0022182A, 1'b0, 1, {2'b00, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0}, gap, mcyc, we_seen);

    // Reset while a load is waiting in MEM.
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #1;
      if_ack = 1'b0; mem_ack = 1'b0;
      if (if_req) begin instr = 32'h8C220004; if_ack = 1'b1; end
      if (mem_req) hit = 1'b1;
    end
    check("reach_mem_before_reset", {31'd0, hit}, 32'd1);
    #2 rst_n = 1'b0; #1;
    check("rst_mid_mem_req", {30'd0, mem_req, if_req}, 32'd0);
    check("rst_mid_retire", retire_cnt, 32'd0);
    sb.delete(); model_cnt = 32'd0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1; #1;
    check("rerst_idle_no_if_req", {31'd0, if_req}, 32'd0);
    @(posedge clk); #1;
    check("rerst_first_if_req", {31'd0, if_req}, 32'd1);

    // Counter wrap from a preset value.
    force dut.retire_cnt_r = 32'hFFFF_FFFE;
    #1 release dut.retire_cnt_r;
    model_cnt = 32'hFFFF_FFFE;
    run_instr(32'h08000010, 1'b0, 0, {2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0}, gap, mcyc, we_seen);
    run_instr(32'h08000010, 1'b0, 0, {2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0}, gap, mcyc, we_seen);
    check("retire_wrapped", retire_cnt, 32'd0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(posedge clk); #1;
      if (if_req) begin instr = 32'hFC000000; if_ack = 1'b1; hit = 1'b1; end
    end
    @(posedge clk); #1 if_ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (if_req || mem_req || pc_wr) cnt++;
    end
    check("trap_illegal_flag", {31'd0, illegal}, 32'd1);
    check("trap_no_requests", cnt, 32'd0);
    check("trap_retire_held", retire_cnt, 32'd0);
`else
    run_instr(32'hFC000000, 1'b0, 0, 9'd0, gap, mcyc, we_seen);
    check("nop_illegal_flag", {31'd0, illegal}, 32'd0);
    check("nop_if_req_back", {31'd0, if_req}, 32'd1);
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
